// File: rtl/bk_adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// bk_adder_pipe_pkg
//
// Purpose:
//     Shared definitions for the pipelined Brent-Kung adder/subtractor:
//     legal parameter ranges, the cut-point encoding used to select which
//     pipeline registers exist, and constant helper functions (log2,
//     power-of-two test and total prefix-tree depth).
//
// Ports:
//     none (package)
//
// Configuration:
//     The optional overflow output is controlled by the macro BK_ADDER_OVF_EN
//     in bk_adder_pipe.sv; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package bk_adder_pipe_pkg;

    localparam int BK_MIN_WIDTH  = 4;
    localparam int BK_MAX_WIDTH  = 64;
    localparam int BK_MAX_STAGES = 3;

    // Pipeline depth doubles as the list of cut points that are populated:
    // each larger value adds one register boundary further upstream.
    typedef enum logic [1:0] {
        CUT_OUT_ONLY = 2'd1,
        CUT_UPSWEEP  = 2'd2,
        CUT_PG       = 2'd3
    } bk_cut_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int bk_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit bk_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Up-sweep levels plus down-sweep levels of the Brent-Kung tree.
    function automatic int bk_levels(input int width);
        return 2 * bk_log2(width) - 1;
    endfunction

endpackage

// File: rtl/bk_pg_cell.sv
// -----------------------------------------------------------------------------
// bk_pg_cell
//
// Purpose:
//     Brent-Kung prefix operator ("black cell"):
//         (g, p) o (g', p') = (g | p & g', p & p')
//     The high-order group is (g_hi, p_hi), the adjacent lower group is
//     (g_lo, p_lo). Used as a gray cell by leaving p_out unread.
//
// Ports:
//     g_hi, p_hi  in   generate/propagate of the upper group
//     g_lo, p_lo  in   generate/propagate of the lower group
//     g_out       out  combined generate
//     p_out       out  combined propagate
// -----------------------------------------------------------------------------
module bk_pg_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/bk_adder_pipe.sv
// -----------------------------------------------------------------------------
// bk_adder_pipe
//
// Purpose:
//     Parametrised, pipelined Brent-Kung prefix adder/subtractor with
//     valid/ready streaming on input and output.
//         in_sub = 0 : out_sum = A + B + cin
//         in_sub = 1 : out_sum = A + ~B + 1   (cin ignored)
//     out_sum is WIDTH+1 bits {carry_out, sum}; in subtract mode the MSB is
//     1 when no borrow occurred.
//
// Parameters:
//     WIDTH   operand width, power of two in 4..64
//     STAGES  number of register stages (= latency), 1..3
//             1: output register only
//             2: plus a register after the up-sweep
//             3: plus a register after P/G generation
//
// Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     in_valid   in   operand beat valid
//     in_ready   out  beat accepted this cycle when in_valid is high
//     in_a       in   operand A (unsigned)
//     in_b       in   operand B (unsigned)
//     in_cin     in   carry-in (add mode only)
//     in_sub     in   subtract select
//     out_valid  out  result valid
//     out_ready  in   downstream accepts result
//     out_sum    out  {carry_out, sum}
//     out_ovf    out  two's-complement overflow
//
// Configuration:
//     BK_ADDER_OVF_EN defined   : out_ovf = c[WIDTH-1] ^ c[WIDTH], registered
//                                 alongside out_sum.
//     BK_ADDER_OVF_EN undefined : out_ovf tied to 0, no overflow logic.
// -----------------------------------------------------------------------------
module bk_adder_pipe
    import bk_adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int LOG    = bk_log2(WIDTH);
    localparam int LEVELS = bk_levels(WIDTH);
    localparam int DOWN   = LEVELS - LOG;

    // Reject illegal configurations at elaboration time.
    generate
        if (!bk_is_pow2(WIDTH) || (WIDTH < BK_MIN_WIDTH) || (WIDTH > BK_MAX_WIDTH)) begin : g_bad_width
            $error("bk_adder_pipe: WIDTH=%0d must be a power of two in %0d..%0d",
                   WIDTH, BK_MIN_WIDTH, BK_MAX_WIDTH);
        end
        if ((STAGES < 1) || (STAGES > BK_MAX_STAGES)) begin : g_bad_stages
            $error("bk_adder_pipe: STAGES=%0d must be in 1..%0d", STAGES, BK_MAX_STAGES);
        end
    endgenerate

    // The whole pipeline freezes as one unit when the output is blocked;
    // interior bubbles are held rather than collapsed.
    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // P/G generation. Subtraction inverts B and forces the carry-in; the
    // carry-in is folded into bit 0's generate (acting as G[-1]) so the
    // prefix tree produces carries directly.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_0;
    logic [WIDTH-1:0] g_0;
    logic             c0_0;

    always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        c0_0   = in_sub | in_cin;
        p_0    = in_a ^ b_eff;
        g_0    = in_a & b_eff;
        g_0[0] = g_0[0] | (p_0[0] & c0_0);
    end

    // Cut point after P/G generation (deepest pipeline only).
    logic [WIDTH-1:0] p_1;
    logic [WIDTH-1:0] g_1;
    logic             c0_1;
    logic             v_1;

    generate
        if (STAGES >= int'(CUT_PG)) begin : g_cut_pg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_1  <= 1'b0;
                    p_1  <= '0;
                    g_1  <= '0;
                    c0_1 <= 1'b0;
                end else if (!stall) begin
                    v_1  <= in_valid;
                    p_1  <= p_0;
                    g_1  <= g_0;
                    c0_1 <= c0_0;
                end
            end
        end else begin : g_pass_pg
            assign v_1  = in_valid;
            assign p_1  = p_0;
            assign g_1  = g_0;
            assign c0_1 = c0_0;
        end
    endgenerate

    // Up-sweep: at level l, every node i with (i+1) a multiple of 2^l
    // absorbs the group ending 2^(l-1) bits below it. After LOG levels,
    // node 2^k-1 holds the full prefix [2^k-1:0].
    generate
        for (genvar l = 0; l <= LOG; l++) begin : g_up
            logic [WIDTH-1:0] g_l;
            logic [WIDTH-1:0] p_l;
            if (l == 0) begin : g_leaf
                assign g_l = g_1;
                assign p_l = p_1;
            end else begin : g_level
                for (genvar i = 0; i < WIDTH; i++) begin : g_node
                    if (((i + 1) % (1 << l)) == 0) begin : g_black
                        bk_pg_cell u_cell (
                            .g_hi  (g_up[l-1].g_l[i]),
                            .p_hi  (g_up[l-1].p_l[i]),
                            .g_lo  (g_up[l-1].g_l[i - (1 << (l - 1))]),
                            .p_lo  (g_up[l-1].p_l[i - (1 << (l - 1))]),
                            .g_out (g_l[i]),
                            .p_out (p_l[i])
                        );
                    end else begin : g_wire
                        assign g_l[i] = g_up[l-1].g_l[i];
                        assign p_l[i] = g_up[l-1].p_l[i];
                    end
                end
            end
        end
    endgenerate

    // Cut point after the up-sweep. The raw bit propagates are carried
    // along because the final sum needs them, not the group propagates.
    logic [WIDTH-1:0] p_2;
    logic [WIDTH-1:0] gu_2;
    logic [WIDTH-1:0] pu_2;
    logic             c0_2;
    logic             v_2;

    generate
        if (STAGES >= int'(CUT_UPSWEEP)) begin : g_cut_up
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_2  <= 1'b0;
                    p_2  <= '0;
                    gu_2 <= '0;
                    pu_2 <= '0;
                    c0_2 <= 1'b0;
                end else if (!stall) begin
                    v_2  <= v_1;
                    p_2  <= p_1;
                    gu_2 <= g_up[LOG].g_l;
                    pu_2 <= g_up[LOG].p_l;
                    c0_2 <= c0_1;
                end
            end
        end else begin : g_pass_up
            assign v_2  = v_1;
            assign p_2  = p_1;
            assign gu_2 = g_up[LOG].g_l;
            assign pu_2 = g_up[LOG].p_l;
            assign c0_2 = c0_1;
        end
    endgenerate

    // Down-sweep: step s works on span 2^(LOG-s). Node k*span + span/2 - 1
    // (k >= 1) already covers the half-span below it from the up-sweep and
    // now absorbs the complete prefix ending at k*span - 1. Only generate
    // is needed from here on, so these are gray cells.
    generate
        for (genvar s = 0; s <= DOWN; s++) begin : g_dn
            logic [WIDTH-1:0] g_s;
            if (s == 0) begin : g_root
                assign g_s = gu_2;
            end else begin : g_level
                localparam int SPAN = 1 << (LOG - s);
                localparam int HALF = SPAN / 2;
                for (genvar i = 0; i < WIDTH; i++) begin : g_node
                    if ((i >= SPAN) && (((i + 1) % SPAN) == HALF)) begin : g_gray
                        logic unused_p;
                        bk_pg_cell u_cell (
                            .g_hi  (g_dn[s-1].g_s[i]),
                            .p_hi  (pu_2[i]),
                            .g_lo  (g_dn[s-1].g_s[i - HALF]),
                            .p_lo  (pu_2[i - HALF]),
                            .g_out (g_s[i]),
                            .p_out (unused_p)
                        );
                    end else begin : g_wire
                        assign g_s[i] = g_dn[s-1].g_s[i];
                    end
                end
            end
        end
    endgenerate

    // Group propagates that the down-sweep never consults (e.g. the
    // whole-word propagate) are deliberately dropped here.
    logic unused_pu;

    assign unused_pu = ^pu_2;

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
    logic [WIDTH:0] carry;
    logic [WIDTH:0] sum_next;

    assign carry    = {g_dn[DOWN].g_s, c0_2};
    assign sum_next = {carry[WIDTH], p_2 ^ carry[WIDTH-1:0]};

    // Output register, present in every configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (!stall) begin
            out_valid <= v_2;
            out_sum   <= sum_next;
        end
    end

`ifdef BK_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic ovf_next;

    assign ovf_next = carry[WIDTH-1] ^ carry[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (!stall) begin
            out_ovf <= ovf_next;
        end
    end
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bk_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_bk_adder_pipe
//
// Purpose:
//     Self-checking bench for bk_adder_pipe (WIDTH=16, STAGES=3). Results are
//     predicted with plain integer arithmetic and queued in order of
//     acceptance; every delivered result is compared against the queue head.
//     Honours BK_ADDER_OVF_EN for the overflow expectation.
// -----------------------------------------------------------------------------
module tb_bk_adder_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = 3;

`ifdef BK_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_ovf;

    bk_adder_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH:0] sum;
        logic           ovf;
    } exp_t;

    exp_t           exp_q[$];
    int             total;
    int             bad;
    int             out_count;
    bit             rand_ready;
    bit             last_acc;
    logic           seen_valid;
    logic           seen_in_ready;
    logic [WIDTH:0] seen_sum;
    logic           seen_ovf;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [WIDTH:0] modelSum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
        longint r;
        if (sub) begin
            r = longint'(a) - longint'(b) + (longint'(1) << WIDTH);
        end else begin
            r = longint'(a) + longint'(b) + longint'(cin);
        end
        return r[WIDTH:0];
    endfunction

    function automatic logic modelOvf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input logic sub);
        longint sa;
        longint sb;
        longint r;
        longint hi;
        longint lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        return OVF_ON && ((r > hi) || (r < lo));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    // One clock: sample at the falling edge, score any leaving beat, record
    // any entering beat, then advance to just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        seen_valid    = out_valid;
        seen_sum      = out_sum;
        seen_ovf      = out_ovf;
        seen_in_ready = in_ready;
        last_acc      = in_valid && in_ready && !rst;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                checkOutput("sum", 64'(out_sum), 64'(e.sum));
                checkOutput("ovf", 64'(out_ovf), 64'(e.ovf));
                out_count++;
            end else begin
                checkOutput("held_sum", 64'(out_sum), 64'(exp_q[0].sum));
            end
        end
        if (last_acc) begin
            e.sum = modelSum(in_a, in_b, in_cin, in_sub);
            e.ovf = modelOvf(in_a, in_b, in_cin, in_sub);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic sendBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        applyStimulus(a, b, cin, sub);
        last_acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (last_acc) break;
        end
        in_valid = 1'b0;
        if (!last_acc) checkOutput("accept_timeout", 64'(last_acc), 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) cycle();
    endtask

    // Single beat into an empty pipe: checks latency and a hand-computed result.
    task automatic singleBeat(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic sub,
                              input logic [WIDTH:0] exp_sum, input logic exp_ovf);
        int cnt;
        out_ready = 1'b1;
        sendBeat(a, b, cin, sub);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cnt++;
            cycle();
            if (seen_valid) break;
        end
        checkOutput({tag, "_latency"}, 64'(cnt), 64'(STAGES));
        checkOutput({tag, "_sum"}, 64'(seen_sum), 64'(exp_sum));
        checkOutput({tag, "_ovf"}, 64'(seen_ovf), 64'(exp_ovf));
        drain();
    endtask

    initial begin
        int bp_start;
        int stale;
        total      = 0;
        bad        = 0;
        out_count  = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        in_sub     = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
        checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst = 1'b0;
        cycle();
        checkOutput("rst_in_ready", 64'(seen_in_ready), 64'd1);

        // Directed arithmetic with latency
        singleBeat("add_65535_123", 16'hFFFF, 16'd123, 1'b0, 1'b0, 17'h1007A, 1'b0);
        singleBeat("sub_5_7", 16'd5, 16'd7, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
        singleBeat("sub_7_5", 16'd7, 16'd5, 1'b1, 1'b1, 17'h10002, 1'b0);
        singleBeat("wrap_ones_plus1", 16'hFFFF, 16'd0, 1'b1, 1'b0, 17'h10000, 1'b0);
        singleBeat("wrap_0_minus1", 16'd0, 16'd1, 1'b0, 1'b1, 17'h0FFFF, 1'b0);
        singleBeat("ovf_7fff_plus1", 16'h7FFF, 16'd1, 1'b0, 1'b0, 17'h08000, OVF_ON);
        singleBeat("ovf_8000_minus1", 16'h8000, 16'd1, 1'b0, 1'b1, 17'h17FFF, OVF_ON);
        singleBeat("ovf_1_plus1", 16'd1, 16'd1, 1'b0, 1'b0, 17'h00002, 1'b0);

        // Backpressure: 8 beats, output blocked for 4 cycles mid-stream
        bp_start  = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendBeat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        out_ready = 1'b0;
        repeat (4) begin
            cycle();
            checkOutput("bp_in_ready", 64'(seen_in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(seen_valid), 64'd1);
        end
        out_ready = 1'b1;
        last_acc  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        in_valid = 1'b0;
        checkOutput("bp_resume_accept", 64'(last_acc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            sendBeat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        checkOutput("bp_count", 64'(out_count - bp_start), 64'd8);

        // Reset mid-stream with 3 beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sendBeat(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rstmid_out_sum", 64'(out_sum), 64'd0);
        exp_q.delete();
        repeat (2) cycle();
        rst   = 1'b0;
        stale = 0;
        repeat (6) begin
            cycle();
            if (seen_valid) stale++;
        end
        checkOutput("rstmid_no_stale", 64'(stale), 64'd0);

        // Randomized streaming: 8-bit operands in add mode, then full width
        // with random subtract, random gaps and random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 1200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                cycle();
            end
            sendBeat(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), 1'b0);
        end
        for (int n = 0; n < 300; n++) begin
            sendBeat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
